muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle signed multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage and receives the same operands X/Y and the same 4-bit operation code S. It replaces the single-cycle `X*Y` / `X/Y` / `X%Y` paths for timing closure. The pipeline stalls on Busy, and mfhi/mflo read Hi/Lo directly.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is required to work.

Ports:
- clk  input  1  single clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- S  input  4  ALU op code. 3 = signed multiply, 4 = signed divide. Start with any other code is ignored.
- X  input  32  signed operand (multiplicand/dividend; also mthi/mtlo data).
- Y  input  32  signed operand (multiplier/divisor).
- WriteHi  input  1  mthi: Hi <= X, honoured only when Busy=0.
- WriteLo  input  1  mtlo: Lo <= X, honoured only when Busy=0.
- Busy  output  1  operation in progress; the pipeline stalls while high.
- Done  output  1  one-cycle pulse; Hi/Lo already hold the new result.
- DivZero  output  1  sticky until the next accepted Start; set by a divide with Y=0.
- Hi  output  32  product[63:32] or remainder.
- Lo  output  32  product[31:0] or quotient.

## Operation
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on Start with S∈{3,4}, except divide with Y=0, which goes IDLE -> FIX.
  - CALC -> FIX when the 5-bit counter reaches 31.
  - FIX -> IDLE always.
- On accept:
  - Latch |X| and |Y| as unsigned magnitudes; |0x80000000| = 0x80000000.
  - Latch the result signs: sign_q = X[31]^Y[31], sign_r = X[31].
  - Latch the op, clear the counter, clear DivZero.
- Multiply: radix-2 shift-add over 32 CALC cycles into a 64-bit accumulator. In FIX, negate the 64-bit result if sign_q, then write {Hi,Lo}.
- Divide: restoring division over 32 CALC cycles, one quotient bit per cycle, with a 33-bit partial remainder. In FIX:
  - Lo = sign_q ? -q : q.
  - Hi = sign_r ? -r : r.
  - This truncates toward zero and matches Verilog signed `/` and `%`.
- Overflow: 0x80000000 / -1 gives Lo=0x80000000, Hi=0. There is no flag.
- Divide by zero: in FIX, Lo=0xFFFFFFFF, Hi=X, and DivZero=1.
- Start while Busy is ignored and does not queue.
- WriteHi/WriteLo while Busy are ignored. In IDLE they take effect at the edge.
  - If they coincide with an accepted Start, the write happens, and FIX later overwrites both registers.
- Simultaneous WriteHi and WriteLo write X to both.

## Timing
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0.
- rst mid-operation aborts immediately; no Done is produced.
- Start is sampled at edge E0. Busy is high from after E0 through the FIX cycle: 33 cycles (32 CALC + 1 FIX).
- Hi/Lo update at the edge ending FIX (E33).
- Done is high for exactly the cycle after E33, with Busy=0 in that cycle.
- Divide by zero: Busy is high for 1 cycle (FIX only). Hi/Lo update at E1, and Done is high in the following cycle.
- A Start during the Done cycle is accepted (back-to-back issue). Done still pulses exactly once for the prior op.
- Hi/Lo are stable (unchanged) from accept until the FIX edge, so a stalled mfhi reads old values.
- Busy and Done are registered outputs; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then multiply X=7, Y=-3:
  - Busy is high for 33 cycles.
  - Done pulses once.
  - Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Divide X=-7, Y=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1), DivZero=0.
- Divide X=0x80000000, Y=0xFFFFFFFF -> Lo=0x80000000, Hi=0. Then divide X=5, Y=0:
  - Busy is high for 1 cycle.
  - Lo=0xFFFFFFFF, Hi=5, DivZero=1.
  - The next accepted Start clears DivZero.
- Multiply 0x80000000 × 0x80000000 -> Hi=0x40000000, Lo=0.
  - Pulse Start, S=4, and WriteHi mid-operation: all ignored.
  - Exactly one Done.
- Back-to-back ops:
  - Start a multiply in the Done cycle of a divide; both results are correct.
  - In IDLE, WriteHi=1 and WriteLo=1 with X=0x12345678 -> Hi=Lo=0x12345678 at the next edge.
  - Start with S=5 is ignored (Busy stays 0).
- Assert rst at CALC cycle 10 -> next cycle Busy=0, Done=0, Hi=Lo=0. A new Start then completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed multiply/divide with architectural HI/LO.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   Start, S        request and op code (3 = signed mul, 4 = signed div),
//                   sampled only while idle
//   X, Y            signed operands; X is also the mthi/mtlo data
//   WriteHi/Lo      mthi/mtlo, honoured only while not busy
//   Busy            operation in progress (registered)
//   Done            one-cycle pulse after Hi/Lo take the new result
//   DivZero         sticky divide-by-zero flag, cleared by the next accept
//   Hi, Lo          product[63:32]/[31:0], or remainder/quotient
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [3:0]       S,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             WriteHi,
  input  logic             WriteLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CW     = $clog2(WIDTH);
  localparam logic [3:0]  OP_MUL = 4'd3;
  localparam logic [3:0]  OP_DIV = 4'd4;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, next_state;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_mag, b_mag;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half shifts the dividend out and the quotient in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic               is_div, sign_q, sign_r;

  logic               accept, host_wr;
  logic [WIDTH-1:0]   abs_x, abs_y;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s, r_s, x_back;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (S == OP_DIV && Y == '0) ? FIX : CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM-derived controls; Busy depends only on the state register
  always_comb begin
    Busy    = (state != IDLE);
    host_wr = (state == IDLE);
    accept  = (state == IDLE) && Start && (S == OP_MUL || S == OP_DIV);
  end

  // Datapath combinational helpers
  always_comb begin
    // Two's-complement negate leaves the most negative value unchanged,
    // which is exactly its unsigned magnitude.
    abs_x   = X[WIDTH-1] ? -X : X;
    abs_y   = Y[WIDTH-1] ? -Y : Y;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    rem_sh  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    trial   = {1'b0, rem_sh} - {2'b00, b_mag};
    prod_s  = sign_q ? -acc : acc;
    q_s     = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_s     = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    // Original X rebuilt from magnitude and sign for the divide-by-zero Hi.
    x_back  = sign_r ? -a_mag : a_mag;
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      Hi      <= '0;
      Lo      <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      cnt     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      acc     <= '0;
      rem     <= '0;
      is_div  <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
    end else begin
      Done <= (state == FIX);

      if (host_wr) begin
        if (WriteHi) Hi <= X;
        if (WriteLo) Lo <= X;
      end

      if (accept) begin
        a_mag   <= abs_x;
        b_mag   <= abs_y;
        sign_q  <= X[WIDTH-1] ^ Y[WIDTH-1];
        sign_r  <= X[WIDTH-1];
        is_div  <= (S == OP_DIV);
        cnt     <= '0;
        DivZero <= 1'b0;
        rem     <= '0;
        acc     <= (S == OP_DIV) ? {{WIDTH{1'b0}}, abs_x} : {{WIDTH{1'b0}}, abs_y};
      end

      if (state == CALC) begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          // Restoring step: keep the shifted remainder when the trial
          // subtraction goes negative.
          if (trial[WIDTH+1]) begin
            rem              <= rem_sh;
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
          end else begin
            rem              <= trial[WIDTH:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
        end
      end

      if (state == FIX) begin
        if (is_div) begin
          if (b_mag == '0) begin
            Lo      <= '1;
            Hi      <= x_back;
            DivZero <= 1'b1;
          end else begin
            Lo <= q_s;
            Hi <= r_s;
          end
        end else begin
          Hi <= prod_s[2*WIDTH-1:WIDTH];
          Lo <= prod_s[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [3:0]  S;
  logic [31:0] X, Y;
  logic        WriteHi, WriteLo;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .S(S), .X(X), .Y(Y),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op at the current negedge and returns at the negedge of its
  // Done cycle, so a following call issues back-to-back.
  task automatic do_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                       input bit disturb, input bit wr_hi);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          e_busy, busy_n, dones;
    longint      p;
    int          xs, ys;
    xs = $signed(x);
    ys = $signed(y);
    e_dz = 1'b0;
    e_busy = 33;
    if (s == 4'd3) begin
      p = longint'(xs) * longint'(ys);
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (y == 0) begin
      e_lo = 32'hFFFF_FFFF;
      e_hi = x;
      e_dz = 1'b1;
      e_busy = 1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e_lo = 32'h8000_0000;
      e_hi = 32'h0;
    end else begin
      e_lo = xs / ys;
      e_hi = xs % ys;
    end

    Start = 1'b1; S = s; X = x; Y = y; WriteHi = wr_hi;
    if (wr_hi) m_hi = x;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; WriteHi = 1'b0;
    check("done_after_accept", Done, 0);
    check("dz_cleared", DivZero, 0);
    check("hi_stable", Hi, m_hi);
    check("lo_stable", Lo, m_lo);
    busy_n = 0;
    dones = 0;
    for (int i = 0; i < 40 && Busy; i++) begin
      busy_n++;
      if (Done) dones++;
      Start = 1'b0; WriteHi = 1'b0; S = s;
      if (disturb && busy_n == 5) begin
        Start = 1'b1; S = 4'd4; WriteHi = 1'b1; X = $urandom;
      end
      if (busy_n == 8) begin
        check("hi_stable_mid", Hi, m_hi);
        check("lo_stable_mid", Lo, m_lo);
      end
      @(negedge clk);
    end
    Start = 1'b0; WriteHi = 1'b0;
    check("busy_cycles", busy_n, e_busy);
    check("done_not_while_busy", dones, 0);
    check("done_pulse", Done, 1);
    check("hi", Hi, e_hi);
    check("lo", Lo, e_lo);
    check("divzero", DivZero, e_dz);
    m_hi = e_hi;
    m_lo = e_lo;
    m_dz = e_dz;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; S = '0; X = '0; Y = '0; WriteHi = 1'b0; WriteLo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dz", DivZero, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);

    do_op(4'd3, 32'd7, 32'hFFFF_FFFD, 0, 0);
    @(negedge clk);
    check("done_one_cycle", Done, 0);
    do_op(4'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(4'd4, 32'd5, 32'd0, 0, 0);
    // DivZero stays set while idle
    @(negedge clk);
    check("dz_sticky", DivZero, 1);
    do_op(4'd3, 32'h8000_0000, 32'h8000_0000, 1, 0);
    // Divide then multiply issued in its Done cycle
    do_op(4'd4, 32'd100, 32'hFFFF_FFF9, 0, 0);
    do_op(4'd3, 32'h0001_2345, 32'hFFFE_0001, 0, 0);
    @(negedge clk);

    WriteHi = 1'b1; WriteLo = 1'b1; X = 32'h1234_5678;
    @(negedge clk);
    WriteHi = 1'b0; WriteLo = 1'b0;
    check("mt_hi", Hi, 32'h1234_5678);
    check("mt_lo", Lo, 32'h1234_5678);
    m_hi = 32'h1234_5678;
    m_lo = 32'h1234_5678;

    Start = 1'b1; S = 4'd5; X = 32'd9; Y = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    check("bad_op_busy", Busy, 0);
    check("bad_op_hi", Hi, m_hi);

    // mthi coinciding with an accepted start
    do_op(4'd4, 32'hDEAD_BEEF, 32'd17, 0, 1);
    @(negedge clk);

    // Reset in the middle of a multiply
    Start = 1'b1; S = 4'd3; X = 32'd1234; Y = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", Busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_hi", Hi, 0);
    check("abort_lo", Lo, 0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    do_op(4'd3, 32'd1234, 32'd5678, 0, 0);

    // Randomized ops, sometimes back-to-back
    for (int n = 0; n < 30; n++) begin
      logic [3:0]  rs;
      logic [31:0] rx, ry;
      rs = ($urandom_range(1) != 0) ? 4'd3 : 4'd4;
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(7))
        0: ry = 32'd0;
        1: ry = $urandom_range(15);
        2: rx = 32'h8000_0000;
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(1) != 0) @(negedge clk);
      do_op(rs, rx, ry, ($urandom_range(3) == 0), 0);
    end
    @(negedge clk);
    check("final_done_low", Done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
